spike_encoder: RTL and testbench
================================

# spike_encoder

Rate-coded spike train generator: the transmit side of the spike interface consumed by the integrate-and-fire neurons. Loads one intensity word per input channel, then emits a programmable number of timesteps, each a NUM_CHANNELS-wide spike vector suitable for driving a neuron's `spike_in` bus. Each channel spikes with frequency proportional to its intensity, either deterministically (phase accumulator) or stochastically (per-channel LFSR). Sits between the pixel/sample source and the first neuron layer.

## Interface
- `NUM_CHANNELS`, 4: number of spike channels.
- `INTENSITY_WIDTH`, 8: bits per channel intensity; must be ≤ 16.
- `STEP_WIDTH`, 16: width of timestep counter and `num_steps`.
- `SEED`, 16'hACE1: base LFSR seed, nonzero.

- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `load_valid`  in  1: intensity vector offered.
- `load_ready`  out  1: encoder can accept intensities.
- `load_data`  in  NUM_CHANNELS*INTENSITY_WIDTH: channel c at bits [c*W +: W].
- `mode`  in  1: 0 = deterministic accumulator, 1 = stochastic LFSR; sampled at `start`.
- `start`  in  1: begin a run; honoured only in IDLE.
- `num_steps`  in  STEP_WIDTH: timesteps to emit; sampled at `start`.
- `step_valid`  out  1: `spike_out` holds a valid timestep.
- `step_ready`  in  1: downstream consumed the timestep.
- `spike_out`  out  NUM_CHANNELS: spike vector of current timestep.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse at end of run.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `load_ready`=1; `load_valid && load_ready` latches all intensities. `start` latches `mode`, `num_steps`, clears step counter; clears phase accumulators; reloads LFSR c with `SEED ^ c` (forced to 1 if result is zero). If `num_steps`==0 → DONE, else compute step 1 → RUN.
- Simultaneous `load_valid` and `start` in IDLE: load wins the same edge; the run uses the newly loaded intensities.
- RUN: `step_valid`=1, `spike_out` and `step_valid` held stable until `step_valid && step_ready`. On handshake: counter++; if counter == num_steps → DONE (`step_valid` drops), else compute next step. `start` and `load_valid` ignored.
- Step computation, mode 0: {carry, phase_c} = phase_c + I_c (INTENSITY_WIDTH+1 bits); spike_c = carry.
- Step computation, mode 1: advance LFSR_c one Galois shift (polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400); spike_c = (I_c > lfsr_c[INTENSITY_WIDTH-1:0]).
- I_c = 0 never spikes in either mode.
- DONE: `done`=1 for exactly one cycle → IDLE.
- Reset (any state, including mid-run): state IDLE; intensities, phases, counter, `spike_out` = 0; LFSRs = seeds; `step_valid`, `busy`, `done` = 0; `load_ready` = 1 once reset is released.

## Timing
- `start` at edge k → `step_valid` high after edge k (one-cycle latency).
- Handshake at edge n → next timestep valid after edge n; with `step_ready` held high, one timestep per cycle.
- Last handshake at edge n → `done` high during cycle n+1, `load_ready` high from cycle n+2.
- `num_steps`=0: `done` pulses the cycle after `start`; no `step_valid`.
- Outputs are registered; no combinational path from `step_ready` to `spike_out`.

## Structure
- Shared package `snn_pkg`: state enum (IDLE, RUN, DONE), `LFSR_TAPS` = 16'hB400, `LFSR_WIDTH` = 16.
- Sub-module `spike_encoder_channel`, instantiated NUM_CHANNELS times in a generate loop. Each instance holds the intensity, phase and LFSR for one channel and produces one spike bit. Control inputs: load, init, advance, mode.
- Top level holds the FSM, step counter and handshake logic.

## Test plan
- Reset defaults: assert `rst`=0 mid-run → all outputs 0 and `load_ready` back to 1 after release. Then load intensities {0,64,128,255}, mode 0, 8 steps, `step_ready`=1 → spike counts {0,2,4,7}.
- Mode 0 exact pattern: I=64, 8 steps → spikes at steps 4 and 8 only. I=255, 4 steps → spikes at steps 2, 3, 4.
- Backpressure: `step_ready` toggled pseudo-randomly → `spike_out` stable while stalled, exactly `num_steps` handshakes, identical spike sequence to the unstalled run.
- `num_steps`=0 → `done` one cycle after `start`, no `step_valid`. `start` asserted during RUN → ignored, step count unchanged.
- Mode 1: I=128, 4096 steps → spike count within 2048±150. Two runs from reset give identical sequences. I=0 → zero spikes.
- Simultaneous `load_valid` and `start` in IDLE → new intensities used. `load_valid` during RUN → `load_ready`=0 and intensities unchanged.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks.
//   state_t    : encoder control states (IDLE, RUN, DONE)
//   LFSR_WIDTH : width of the per-channel pseudo-random generators
//   LFSR_TAPS  : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   lfsr_step  : one right-shifting Galois LFSR advance
//   lfsr_seed  : per-channel seed derivation (base ^ index, never zero)
package snn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int LFSR_WIDTH = 16;
   localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   // An all-zero LFSR would lock up, so a zero result is replaced by 1.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_seed(input logic [LFSR_WIDTH-1:0] base,
                                                       input int unsigned idx);
      logic [LFSR_WIDTH-1:0] s;
      s = base ^ LFSR_WIDTH'(idx);
      lfsr_seed = (s == '0) ? {{(LFSR_WIDTH-1){1'b0}}, 1'b1} : s;
   endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Load and timestep channels of the spike encoder.
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready; the source holds valid and its data stable until then.
//   load_valid/load_ready/load_data : intensity vector, channel c at [c*W +: W]
//   step_valid/step_ready/spike_out : one spike vector per timestep
// master = the side feeding intensities and consuming timesteps,
// slave  = the encoder.
interface spike_encoder_if #(
   parameter int NUM_CHANNELS    = 4,
   parameter int INTENSITY_WIDTH = 8
);
   logic                                    load_valid;
   logic                                    load_ready;
   logic [NUM_CHANNELS*INTENSITY_WIDTH-1:0] load_data;
   logic                                    step_valid;
   logic                                    step_ready;
   logic [NUM_CHANNELS-1:0]                 spike_out;

   modport master (
      output load_valid, load_data, step_ready,
      input  load_ready, step_valid, spike_out
   );

   modport slave (
      input  load_valid, load_data, step_ready,
      output load_ready, step_valid, spike_out
   );
endinterface

// File: rtl/spike_encoder_channel.sv
// One encoder channel: intensity, phase accumulator, LFSR and spike bit.
//   clk, rst       : clock, asynchronous active-low reset
//   load           : capture load_intensity
//   load_intensity : new intensity word
//   init           : clear phase and reseed LFSR (start of a run)
//   advance        : compute the next timestep's spike
//   mode           : 0 = phase accumulator, 1 = LFSR comparison
//   spike          : registered spike bit of the current timestep
// load/init/advance may coincide on the start edge; the step computed then
// must see the new intensity and the freshly cleared phase/seed, so the
// datapath works on the "effective" values rather than the registers.
module spike_encoder_channel
   import snn_pkg::*;
#(
   parameter int                    INTENSITY_WIDTH = 8,
   parameter logic [LFSR_WIDTH-1:0] SEED            = 16'h0001
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [INTENSITY_WIDTH-1:0] load_intensity,
   input  logic                       init,
   input  logic                       advance,
   input  logic                       mode,
   output logic                       spike
);

   logic [INTENSITY_WIDTH-1:0] intensity;
   logic [INTENSITY_WIDTH-1:0] phase;
   logic [LFSR_WIDTH-1:0]      lfsr;

   logic [INTENSITY_WIDTH-1:0] int_eff;
   logic [INTENSITY_WIDTH-1:0] phase_base;
   logic [LFSR_WIDTH-1:0]      lfsr_base;
   logic [INTENSITY_WIDTH:0]   sum;
   logic [LFSR_WIDTH-1:0]      lfsr_adv;
   logic                       spike_next;

   always_comb begin
      int_eff    = load ? load_intensity : intensity;
      phase_base = init ? '0 : phase;
      lfsr_base  = init ? SEED : lfsr;
      sum        = {1'b0, phase_base} + {1'b0, int_eff};
      lfsr_adv   = lfsr_step(lfsr_base);
      // Carry-out of the accumulator is the deterministic spike.
      spike_next = mode ? (int_eff > lfsr_adv[INTENSITY_WIDTH-1:0]) : sum[INTENSITY_WIDTH];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         intensity <= '0;
         phase     <= '0;
         lfsr      <= SEED;
         spike     <= 1'b0;
      end else begin
         if (load) intensity <= load_intensity;
         if (advance) begin
            phase <= sum[INTENSITY_WIDTH-1:0];
            lfsr  <= lfsr_adv;
            spike <= spike_next;
         end else if (init) begin
            phase <= '0;
            lfsr  <= SEED;
         end
      end
   end

endmodule

// File: rtl/spike_encoder.sv
// Rate-coded spike train generator.
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : load channel (intensities) and step channel (spike vectors)
//   mode      : 0 deterministic, 1 stochastic; sampled at start
//   start     : begin a run (IDLE only)
//   num_steps : timesteps to emit; sampled at start
//   busy      : high while emitting timesteps
//   done      : one-cycle pulse after the last timestep
//   dbg_state : current control state
// Each timestep is computed on the edge that enters RUN or completes the
// previous handshake, so spike_out is always a register output.
module spike_encoder
   import snn_pkg::*;
#(
   parameter int                    NUM_CHANNELS    = 4,
   parameter int                    INTENSITY_WIDTH = 8,
   parameter int                    STEP_WIDTH      = 16,
   parameter logic [LFSR_WIDTH-1:0] SEED            = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   spike_encoder_if.slave        bus,
   input  logic                  mode,
   input  logic                  start,
   input  logic [STEP_WIDTH-1:0] num_steps,
   output logic                  busy,
   output logic                  done,
   output state_t                dbg_state
);

   state_t                  state, state_next;
   logic [STEP_WIDTH-1:0]   count;
   logic [STEP_WIDTH-1:0]   count_inc;
   logic [STEP_WIDTH-1:0]   steps_reg;
   logic                    mode_reg;
   logic                    mode_eff;
   logic                    load_en;
   logic                    init;
   logic                    advance;
   logic [NUM_CHANNELS-1:0] spike_vec;

   assign count_inc = count + STEP_WIDTH'(1);

   always_comb begin
      state_next = state;
      load_en    = 1'b0;
      init       = 1'b0;
      advance    = 1'b0;
      mode_eff   = mode_reg;
      case (state)
         IDLE: begin
            load_en = bus.load_valid;
            if (start) begin
               init     = 1'b1;
               mode_eff = mode;
               if (num_steps == '0) begin
                  state_next = DONE;
               end else begin
                  advance    = 1'b1;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (bus.step_ready) begin
               if (count_inc == steps_reg) state_next = DONE;
               else                        advance    = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         steps_reg <= '0;
         mode_reg  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            count     <= '0;
            steps_reg <= num_steps;
            mode_reg  <= mode;
         end else if (state == RUN && bus.step_ready) begin
            count <= count_inc;
         end
      end
   end

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      localparam logic [LFSR_WIDTH-1:0] CH_SEED = lfsr_seed(SEED, c);
      spike_encoder_channel #(
         .INTENSITY_WIDTH (INTENSITY_WIDTH),
         .SEED            (CH_SEED)
      ) u_ch (
         .clk            (clk),
         .rst            (rst),
         .load           (load_en),
         .load_intensity (bus.load_data[c*INTENSITY_WIDTH +: INTENSITY_WIDTH]),
         .init           (init),
         .advance        (advance),
         .mode           (mode_eff),
         .spike          (spike_vec[c])
      );
   end

   assign bus.spike_out  = spike_vec;
   assign bus.load_ready = (state == IDLE);
   assign bus.step_valid = (state == RUN);
   assign busy           = (state == RUN);
   assign done           = (state == DONE);
   assign dbg_state      = state;

endmodule

// File: tb/tb_spike_encoder.sv
module tb_spike_encoder;
   import snn_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 16;
   localparam logic [15:0] SEED = 16'hACE1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   spike_encoder_if #(.NUM_CHANNELS(N), .INTENSITY_WIDTH(W)) bus ();

   logic          mode_i;
   logic          start_i;
   logic [SW-1:0] num_steps_i;
   logic          busy;
   logic          done;
   state_t        dbg_state;

   spike_encoder #(
      .NUM_CHANNELS    (N),
      .INTENSITY_WIDTH (W),
      .STEP_WIDTH      (SW),
      .SEED            (SEED)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .mode      (mode_i),
      .start     (start_i),
      .num_steps (num_steps_i),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   int errors = 0;
   int checks = 0;

   logic [W-1:0] intens [N];
   logic [N-1:0] exp_q [$];
   logic [N-1:0] got_q [$];
   logic [N-1:0] ref_q [$];
   int           cnt [N];

   // ---------------- reference model ----------------
   // Deterministic: the k-th step spikes when floor(k*I/2^W) increments.
   // Stochastic: Galois LFSR per channel, spike when I exceeds its low bits.
   task automatic build_model(input bit m, input int steps);
      logic [15:0] lf [N];
      exp_q.delete();
      for (int c = 0; c < N; c++) begin
         lf[c] = SEED ^ 16'(c);
         if (lf[c] == 16'h0) lf[c] = 16'h1;
      end
      for (int k = 1; k <= steps; k++) begin
         logic [N-1:0] v;
         for (int c = 0; c < N; c++) begin
            if (!m) begin
               v[c] = ((k * int'(intens[c])) >> W) != (((k - 1) * int'(intens[c])) >> W);
            end else begin
               lf[c] = lf[c][0] ? ((lf[c] >> 1) ^ 16'hB400) : (lf[c] >> 1);
               v[c]  = intens[c] > lf[c][W-1:0];
            end
         end
         exp_q.push_back(v);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive_idle();
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      bus.step_ready = 1'b0;
      start_i        = 1'b0;
      mode_i         = 1'b0;
      num_steps_i    = '0;
   endtask

   task automatic pack_load();
      for (int c = 0; c < N; c++) bus.load_data[c*W +: W] = intens[c];
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic do_load();
      pack_load();
      bus.load_valid = 1'b1;
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
   endtask

   task automatic rand_intens();
      for (int c = 0; c < N; c++) intens[c] = W'($urandom_range(255));
   endtask

   // Starts a run, consumes every timestep with random backpressure and
   // scores each handshaked vector against the model.
   task automatic run_check(input bit m, input int steps, input int ready_pct,
                            input bit poke, input bit with_load, input string tag);
      int           hs;
      int           cycles;
      int           budget;
      bit           r;
      bit           v;
      bit           stalled_prev;
      logic [N-1:0] prev_spk;
      logic [N-1:0] e;
      build_model(m, steps);
      got_q.delete();
      for (int c = 0; c < N; c++) cnt[c] = 0;
      mode_i      = m;
      num_steps_i = SW'(steps);
      start_i     = 1'b1;
      if (with_load) begin
         pack_load();
         bus.load_valid = 1'b1;
      end
      @(posedge clk); #1;
      start_i        = 1'b0;
      bus.load_valid = 1'b0;
      mode_i         = ~m;
      num_steps_i    = SW'($urandom_range(1, 3));
      if (steps == 0) begin
         checks++;
         if ({done, bus.step_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s zero_start: done,step_valid=%b expected 10", tag, {done, bus.step_valid});
         end
         @(posedge clk); #1;
         checks++;
         if ({done, bus.step_valid, bus.load_ready} !== 3'b001) begin
            errors++;
            $display("FAIL %s zero_after: done,step_valid,load_ready=%b expected 001", tag,
                     {done, bus.step_valid, bus.load_ready});
         end
         return;
      end
      hs           = 0;
      cycles       = 0;
      budget       = steps * 20 + 20;
      stalled_prev = 1'b0;
      prev_spk     = '0;
      while (hs < steps && cycles < budget) begin
         checks++;
         if ({bus.step_valid, busy, bus.load_ready} !== 3'b110) begin
            errors++;
            $display("FAIL %s run_flags: step_valid,busy,load_ready=%b expected 110", tag,
                     {bus.step_valid, busy, bus.load_ready});
         end
         if (stalled_prev) begin
            checks++;
            if (bus.spike_out !== prev_spk) begin
               errors++;
               $display("FAIL %s stall_hold: spike_out=%b expected %b", tag, bus.spike_out, prev_spk);
            end
         end
         r              = ($urandom_range(99) < ready_pct);
         bus.step_ready = r;
         if (poke) begin
            start_i        = 1'($urandom_range(1));
            num_steps_i    = SW'($urandom_range(1, 5));
            bus.load_valid = 1'($urandom_range(1));
            bus.load_data  = {N*W{1'b0}} | 32'($urandom);
         end
         prev_spk = bus.spike_out;
         v        = bus.step_valid;
         @(posedge clk); #1;
         if (v && r) begin
            hs++;
            got_q.push_back(prev_spk);
            for (int c = 0; c < N; c++) cnt[c] += int'(prev_spk[c]);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++;
            if (prev_spk !== e) begin
               errors++;
               $display("FAIL %s step%0d: spike_out=%b expected %b", tag, hs, prev_spk, e);
            end
            if (hs == steps) begin
               checks++;
               if ({done, bus.step_valid} !== 2'b10) begin
                  errors++;
                  $display("FAIL %s done_pulse: done,step_valid=%b expected 10", tag,
                           {done, bus.step_valid});
               end
            end
         end
         stalled_prev = v && !r;
         cycles++;
      end
      bus.step_ready = 1'b0;
      start_i        = 1'b0;
      bus.load_valid = 1'b0;
      checks++;
      if (hs != steps) begin
         errors++;
         $display("FAIL %s handshakes: got %0d expected %0d (cycle budget)", tag, hs, steps);
      end
      @(posedge clk); #1;
      checks++;
      if ({done, busy, bus.load_ready} !== 3'b001) begin
         errors++;
         $display("FAIL %s back_idle: done,busy,load_ready=%b expected 001", tag,
                  {done, busy, bus.load_ready});
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({bus.step_valid, bus.spike_out, busy, done, bus.load_ready} !== {1'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000_0001",
                  {bus.step_valid, bus.spike_out, busy, done, bus.load_ready});
      end
      intens = '{8'd0, 8'd64, 8'd128, 8'd255};
      do_load();
      mode_i         = 1'b0;
      num_steps_i    = 16'd8;
      start_i        = 1'b1;
      bus.step_ready = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      checks++;
      if ({bus.step_valid, bus.spike_out, busy, done} !== 7'b0) begin
         errors++;
         $display("FAIL reset_midrun: got %b expected 0000000",
                  {bus.step_valid, bus.spike_out, busy, done});
      end
      checks++;
      if (dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
      end
      @(posedge clk); #1;
      rst            = 1'b1;
      bus.step_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.load_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_load_ready: got %b expected 1", bus.load_ready);
      end
      // intensities were cleared by reset
      intens = '{8'd0, 8'd0, 8'd0, 8'd0};
      run_check(1'b0, 4, 100, 1'b0, 1'b0, "post_reset");
      intens = '{8'd0, 8'd64, 8'd128, 8'd255};
      do_load();
      run_check(1'b0, 8, 100, 1'b0, 1'b0, "rate8");
      checks++;
      if (cnt[0] != 0 || cnt[1] != 2 || cnt[2] != 4 || cnt[3] != 7) begin
         errors++;
         $display("FAIL rate8_counts: got {%0d,%0d,%0d,%0d} expected {0,2,4,7}",
                  cnt[0], cnt[1], cnt[2], cnt[3]);
      end
   endtask

   task automatic test_mode0_pattern();
      logic [7:0] mask;
      intens = '{8'd64, 8'd255, 8'd128, 8'd0};
      do_load();
      run_check(1'b0, 8, 100, 1'b0, 1'b0, "pat64");
      mask = '0;
      for (int k = 0; k < 8 && k < got_q.size(); k++) mask[k] = got_q[k][0];
      checks++;
      if (mask !== 8'b1000_1000) begin
         errors++;
         $display("FAIL pat64_steps: got %b expected 10001000", mask);
      end
      run_check(1'b0, 4, 100, 1'b0, 1'b0, "pat255");
      mask = '0;
      for (int k = 0; k < 4 && k < got_q.size(); k++) mask[k] = got_q[k][1];
      checks++;
      if (mask !== 8'b0000_1110) begin
         errors++;
         $display("FAIL pat255_steps: got %b expected 00001110", mask);
      end
   endtask

   task automatic test_back_to_back();
      for (int m = 0; m < 2; m++) begin
         rand_intens();
         do_load();
         run_check(1'(m), 40, 100, 1'b0, 1'b0, "unstalled");
         ref_q = got_q;
         run_check(1'(m), 40, 40, 1'b0, 1'b0, "stalled");
         checks++;
         if (got_q != ref_q) begin
            errors++;
            $display("FAIL stall_sequence: mode %0d got %0d steps, differs from %0d unstalled steps",
                     m, got_q.size(), ref_q.size());
         end
      end
   endtask

   task automatic test_zero_steps();
      run_check(1'b0, 0, 100, 1'b0, 1'b0, "zero");
   endtask

   task automatic test_start_during_run();
      rand_intens();
      do_load();
      // random start/load_valid pokes while running; model keeps old intensities
      run_check(1'b0, 20, 50, 1'b1, 1'b0, "poke");
      run_check(1'b1, 20, 70, 1'b0, 1'b0, "poke_after");
   endtask

   task automatic test_mode1();
      intens = '{8'd128, 8'd128, 8'd0, 8'd128};
      do_load();
      run_check(1'b1, 4096, 100, 1'b0, 1'b0, "lfsr4096");
      for (int c = 0; c < N; c++) begin
         if (c == 2) begin
            checks++;
            if (cnt[c] != 0) begin
               errors++;
               $display("FAIL lfsr_zero: ch%0d count %0d expected 0", c, cnt[c]);
            end
         end else begin
            checks++;
            if (cnt[c] < 2048 - 150 || cnt[c] > 2048 + 150) begin
               errors++;
               $display("FAIL lfsr_rate: ch%0d count %0d expected 2048+-150", c, cnt[c]);
            end
         end
      end
      rand_intens();
      do_reset();
      do_load();
      run_check(1'b1, 64, 100, 1'b0, 1'b0, "repeat_a");
      ref_q = got_q;
      do_reset();
      do_load();
      run_check(1'b1, 64, 100, 1'b0, 1'b0, "repeat_b");
      checks++;
      if (got_q != ref_q) begin
         errors++;
         $display("FAIL lfsr_repeat: second run (%0d steps) differs from first (%0d steps)",
                  got_q.size(), ref_q.size());
      end
   endtask

   task automatic test_load_and_start();
      rand_intens();
      do_load();
      rand_intens();
      intens[0] = 8'd200;
      run_check(1'b0, 16, 100, 1'b0, 1'b1, "load_start");
      run_check(1'b1, 16, 60, 1'b0, 1'b0, "load_start_keep");
   endtask

   initial begin
      do_reset();
      test_reset();
      test_mode0_pattern();
      test_back_to_back();
      test_zero_steps();
      test_start_during_run();
      test_mode1();
      test_load_and_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
